conv2d_seq_engine: RTL and testbench
====================================

# conv2d_seq_engine

Sequential, parametrised 2-D causal convolution engine: generalises the fixed 4×4 combinational convolution to an N×N input matrix `x` and N×N kernel `h`. It computes every output term `y[i][j]` with full-precision unsigned arithmetic on a single time-shared multiplier, not just the first four. Matrices are loaded through a write port. Computation is started explicitly, and results stream out in raster order over a valid/ready handshake.

## Interface
- `N`, 4: matrix dimension; `x`, `h` and `y` are all N×N; N ≥ 2.
- `DW`, 4: unsigned element width of `x` and `h`.
- `AW`, `$clog2(N)`: row and column index width (derived).
- `OW`, `2*DW + $clog2(N*N)`: output width, which makes overflow impossible (derived).
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `ld_valid` input 1: matrix-element write request.
- `ld_ready` output 1: write accepted; high only in IDLE.
- `ld_sel` input 1: write target; 0 = `x`, 1 = `h`.
- `ld_row`, `ld_col` input AW: element index.
- `ld_data` input DW: element value.
- `start` input 1: begin computation; sampled only in IDLE.
- `busy` output 1: high from the cycle after `start` is accepted until `done`.
- `done` output 1: one-cycle pulse after the last output transfer.
- `y_valid` output 1: output element available.
- `y_ready` input 1: sink accepts the output.
- `y_row`, `y_col` output AW: index of the current output.
- `y_data` output OW: value of `y[y_row][y_col]`.

## Operation
- Computes `y[i][j] = Σ_{a=0..i} Σ_{b=0..j} x[a][b]·h[i−a][j−b]`, which is the causal/truncated linear convolution; all terms are unsigned.
- Write storage:
  - `x` and `h` are held in N·N·DW register arrays.
  - A write commits when `ld_valid && ld_ready`.
  - Writes are ignored while `busy`.
- FSM states:
  - IDLE:
    - `ld_ready` = 1.
    - `start` moves to MAC with (i, j, a, b) = 0 and the accumulator cleared.
  - MAC:
    - One product per cycle: `acc += x[a][b]·h[i−a][j−b]`.
    - b increments to j, then wraps to 0 and a increments.
    - After the term (a = i, b = j), go to EMIT.
  - EMIT:
    - `y_valid` = 1 and `y_data` = `acc`.
    - On `y_ready`, advance (i, j) in raster order (j first) and clear `acc`.
    - If more outputs remain, go to MAC; after (N−1, N−1), go to DONE.
  - DONE: `done` = 1 for one cycle, then return to IDLE.
- `start` is ignored outside IDLE.
- A `start` in the same cycle as an accepted write: the write commits first, and the computation uses the new value.
- Matrix contents persist across runs, so they can be partially rewritten between runs.

## Timing
- Reset values:
  - Control outputs: `busy` = 0, `done` = 0, `y_valid` = 0.
  - Data outputs: `y_row` = 0, `y_col` = 0, `y_data` = 0.
  - `ld_ready` = 1.
  - State: FSM in IDLE, `x` and `h` arrays cleared to 0, accumulator cleared to 0.
- Reset mid-run aborts immediately: next cycle is IDLE, with no `done` pulse and no further `y_valid`.
- With `y_ready` tied high, output (i, j) takes (i+1)(j+1) MAC cycles plus 1 EMIT cycle.
- Total from `start` acceptance to `done` = (N(N+1)/2)² + N² + 1 cycles; N = 4 gives 100 + 16 + 1 = 117.
- While `y_valid && !y_ready`:
  - `y_data`, `y_row` and `y_col` are held stable.
  - The accumulator and indices are frozen.
- `y_valid` never drops without a transfer (except on reset).
- The multiplier and adder are combinational into the registered accumulator; there is no pipeline inside the MAC.

## Structure
- Package `conv2d_pkg`:
  - state enum `conv_state_t` {IDLE, MAC, EMIT, DONE};
  - width helper function `conv_ow(N, DW)`.
- Sub-module `conv2d_mac_unit`:
  - DW×DW multiply feeding an OW-bit accumulator;
  - `clr` and `en` inputs;
  - synchronous active-low reset.
- Top level holds the register arrays, index counters, FSM and handshake.

## Test plan
- Reset, then release:
  - all outputs equal 0, except `ld_ready` = 1;
  - assert reset mid-run at cycle 40: IDLE next cycle, no `done` pulse.
- N = 4, DW = 4, all `x` = 1 and all `h` = 1:
  - outputs `y[i][j]` = (i+1)(j+1) in raster order: `y[0][0]` = 1, `y[1][1]` = 4, `y[3][3]` = 16;
  - `done` is high exactly 117 cycles after `start`.
- All elements = 15: `y[3][3]` = 16·225 = 3600 and `y[0][0]` = 225; no overflow in OW = 12.
- Impulse `x[0][0]` = 1, all other `x` = 0, `h[r][c]` = 4r + c:
  - `y` equals `h` exactly;
  - swap roles so `h` is the impulse: `y` equals `x`.
- Backpressure: hold `y_ready` low for 5 cycles on output (0, 3):
  - `y_valid`, `y_data` = 4 and indices are held stable;
  - the next output follows correctly after the transfer;
  - total cycles increase by exactly 5.
- Protocol:
  - `start` and `ld_valid` while busy are ignored, so results are unchanged;
  - a write in the same cycle as `start` is used by the run.

Source files
------------

// File: rtl/conv2d_pkg.sv
// Shared types and width helpers for the sequential 2-D causal convolution engine.
package conv2d_pkg;

  typedef enum logic [1:0] {StIdle, StMac, StEmit, StDone} conv_state_t;

  // Output width that can hold N*N full-precision DW x DW products without overflow.
  function automatic int unsigned conv_ow(input int unsigned n, input int unsigned dw);
    return 2 * dw + $clog2(n * n);
  endfunction

endpackage

// File: rtl/conv2d_mac_unit.sv
// Single DW x DW multiplier feeding a registered OW-bit accumulator with clear and enable.
module conv2d_mac_unit #(
  parameter int unsigned DW = 4,
  parameter int unsigned OW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] op_a,
  input  logic [DW-1:0] op_b,
  output logic [OW-1:0] acc
);

  logic [2*DW-1:0] prod;

  assign prod = op_a * op_b;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + OW'(prod);
    end
  end

endmodule

// File: rtl/conv2d_seq_engine.sv
// N x N causal 2-D convolution on one time-shared MAC; matrices loaded via a write port,
// results streamed in raster order over valid/ready.
module conv2d_seq_engine
  import conv2d_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 4,
  parameter int unsigned AW = $clog2(N),
  parameter int unsigned OW = conv_ow(N, DW)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic          ld_sel,
  input  logic [AW-1:0] ld_row,
  input  logic [AW-1:0] ld_col,
  input  logic [DW-1:0] ld_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          y_valid,
  input  logic          y_ready,
  output logic [AW-1:0] y_row,
  output logic [AW-1:0] y_col,
  output logic [OW-1:0] y_data
);

  localparam logic [AW-1:0] Last = AW'(N - 1);

  logic [DW-1:0] x_q [N][N];
  logic [DW-1:0] h_q [N][N];

  conv_state_t   state_q;
  logic [AW-1:0] i_q, j_q, a_q, b_q;
  logic [AW-1:0] h_r, h_c;
  logic          mac_clr, mac_en;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          x_q[r][c] <= '0;
          h_q[r][c] <= '0;
        end
      end
    end else if (ld_valid && ld_ready) begin
      if (ld_sel) h_q[ld_row][ld_col] <= ld_data;
      else        x_q[ld_row][ld_col] <= ld_data;
    end
  end

  always_comb begin
    h_r     = i_q - a_q;
    h_c     = j_q - b_q;
    mac_en  = (state_q == StMac);
    // Clear on run start and on every completed output transfer.
    mac_clr = (state_q == StIdle && start) || (state_q == StEmit && y_ready);
  end

  conv2d_mac_unit #(
    .DW(DW),
    .OW(OW)
  ) u_mac (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (mac_clr),
    .en   (mac_en),
    .op_a (x_q[a_q][b_q]),
    .op_b (h_q[h_r][h_c]),
    .acc  (y_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      i_q      <= '0;
      j_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      y_valid  <= 1'b0;
      ld_ready <= 1'b1;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StMac;
            i_q      <= '0;
            j_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            busy     <= 1'b1;
            ld_ready <= 1'b0;
          end
        end
        StMac: begin
          if (a_q == i_q && b_q == j_q) begin
            state_q <= StEmit;
            y_valid <= 1'b1;
          end else if (b_q == j_q) begin
            b_q <= '0;
            a_q <= a_q + 1'b1;
          end else begin
            b_q <= b_q + 1'b1;
          end
        end
        StEmit: begin
          if (y_ready) begin
            y_valid <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            if (i_q == Last && j_q == Last) begin
              state_q <= StDone;
              done    <= 1'b1;
              busy    <= 1'b0;
              i_q     <= '0;
              j_q     <= '0;
            end else begin
              state_q <= StMac;
              if (j_q == Last) begin
                j_q <= '0;
                i_q <= i_q + 1'b1;
              end else begin
                j_q <= j_q + 1'b1;
              end
            end
          end
        end
        StDone: begin
          state_q  <= StIdle;
          ld_ready <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign y_row = i_q;
  assign y_col = j_q;

endmodule

// File: tb/tb_conv2d_seq_engine.sv
// Self-checking bench for conv2d_seq_engine against a plain-arithmetic convolution model.
module tb_conv2d_seq_engine;

  localparam int N  = 4;
  localparam int DW = 4;
  localparam int AW = 2;
  localparam int OW = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ld_valid, ld_ready, ld_sel;
  logic [AW-1:0] ld_row, ld_col;
  logic [DW-1:0] ld_data;
  logic          start, busy, done, y_valid, y_ready;
  logic [AW-1:0] y_row, y_col;
  logic [OW-1:0] y_data;

  always #5 clk = ~clk;

  conv2d_seq_engine #(
    .N (N),
    .DW(DW),
    .AW(AW),
    .OW(OW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ld_valid(ld_valid),
    .ld_ready(ld_ready),
    .ld_sel  (ld_sel),
    .ld_row  (ld_row),
    .ld_col  (ld_col),
    .ld_data (ld_data),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .y_row   (y_row),
    .y_col   (y_col),
    .y_data  (y_data)
  );

  int vectors    = 0;
  int miscompares = 0;
  int x_m [N][N];
  int h_m [N][N];
  int y_got [N][N];

  typedef struct {
    int xv;
    int hv;
    int r;
    int c;
    int exp;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int model_y(input int i, input int j);
    int s;
    s = 0;
    for (int a = 0; a <= i; a++)
      for (int b = 0; b <= j; b++)
        s += x_m[a][b] * h_m[i-a][j-b];
    return s;
  endfunction

  task automatic write_el(input bit sel, input int r, input int c, input int d);
    ld_valid = 1'b1;
    ld_sel   = sel;
    ld_row   = AW'(r);
    ld_col   = AW'(c);
    ld_data  = DW'(d);
    if (sel) h_m[r][c] = d;
    else     x_m[r][c] = d;
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic fill(input int xv, input int hv);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        write_el(1'b0, r, c, xv);
        write_el(1'b1, r, c, hv);
      end
  endtask

  task automatic fill_random();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        write_el(1'b0, r, c, int'($urandom_range(0, 15)));
        write_el(1'b1, r, c, int'($urandom_range(0, 15)));
      end
  endtask

  // mode 0: ready high except sn stall cycles on output (sr, sc); mode 1: random ready.
  task automatic run(input int mode, input int sr, input int sc, input int sn, input bit inject,
                     input bit wr_with_start, input int wr_data, output int cycles);
    int k, cnt, stalls, left;
    bit rdy, prev_stall, got_done;
    if (wr_with_start) begin
      ld_valid = 1'b1;
      ld_sel   = 1'b0;
      ld_row   = AW'(1);
      ld_col   = AW'(1);
      ld_data  = DW'(wr_data);
      x_m[1][1] = wr_data;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ld_valid = 1'b0;
    k = 0; cnt = 1; stalls = 0; left = sn; prev_stall = 0; got_done = 0; cycles = 0;
    while (cnt < 3000 && !got_done) begin
      if (inject && cnt == 10) begin
        start    = 1'b1;
        ld_valid = 1'b1;
        ld_sel   = 1'b0;
        ld_row   = '0;
        ld_col   = '0;
        ld_data  = DW'(x_m[0][0] ^ 15);
      end else if (inject && cnt == 11) begin
        start    = 1'b0;
        ld_valid = 1'b0;
      end
      if (prev_stall) check("valid_held", int'(y_valid), 1);
      if (done) begin
        got_done = 1;
        cycles   = cnt;
      end else if (y_valid) begin
        if (k < N * N) begin
          check("y_row", int'(y_row), k / N);
          check("y_col", int'(y_col), k % N);
          check("y_data", int'(y_data), model_y(k / N, k % N));
        end
        if (mode == 1) rdy = ($urandom_range(0, 3) != 0);
        else if (int'(y_row) == sr && int'(y_col) == sc && left > 0) begin
          rdy = 0;
          left--;
        end else rdy = 1;
        y_ready    = rdy;
        prev_stall = !rdy;
        if (rdy) begin
          if (k < N * N) y_got[k / N][k % N] = int'(y_data);
          k++;
        end else stalls++;
      end else begin
        y_ready    = 1'b1;
        prev_stall = 0;
      end
      if (!got_done) begin
        @(negedge clk);
        cnt++;
      end
    end
    y_ready = 1'b1;
    check("run_done_seen", int'(got_done), 1);
    check("output_count", k, N * N);
    check("run_cycles", cycles, 117 + stalls);
    @(negedge clk);
    check("done_one_cycle", int'(done), 0);
    check("ld_ready_after", int'(ld_ready), 1);
  endtask

  initial begin
    int cyc, cnt;
    rst_n = 1'b0; ld_valid = 1'b0; ld_sel = 1'b0; ld_row = '0; ld_col = '0; ld_data = '0;
    start = 1'b0; y_ready = 1'b1;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        x_m[r][c] = 0;
        h_m[r][c] = 0;
      end
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_y_valid", int'(y_valid), 0);
    check("rst_y_row", int'(y_row), 0);
    check("rst_y_col", int'(y_col), 0);
    check("rst_y_data", int'(y_data), 0);
    check("rst_ld_ready", int'(ld_ready), 1);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ld_ready", int'(ld_ready), 1);

    tbl[0] = '{1, 1, 0, 0, 1};
    tbl[1] = '{1, 1, 1, 1, 4};
    tbl[2] = '{1, 1, 3, 3, 16};
    tbl[3] = '{15, 15, 3, 3, 3600};
    tbl[4] = '{15, 15, 0, 0, 225};
    tbl[5] = '{2, 3, 1, 2, 36};
    for (int t = 0; t < 6; t++) begin
      fill(tbl[t].xv, tbl[t].hv);
      run(0, 0, 0, 0, 1'b0, 1'b0, 0, cyc);
      check("tbl_cycles_117", cyc, 117);
      check("tbl_y", y_got[tbl[t].r][tbl[t].c], tbl[t].exp);
    end

    // Impulse in x reproduces h, then impulse in h reproduces x.
    fill(0, 0);
    write_el(1'b0, 0, 0, 1);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) write_el(1'b1, r, c, 4 * r + c);
    run(0, 0, 0, 0, 1'b0, 1'b0, 0, cyc);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) check("impulse_x", y_got[r][c], 4 * r + c);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        write_el(1'b0, r, c, 4 * r + c);
        write_el(1'b1, r, c, (r == 0 && c == 0) ? 1 : 0);
      end
    run(0, 0, 0, 0, 1'b0, 1'b0, 0, cyc);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) check("impulse_h", y_got[r][c], 4 * r + c);

    // Backpressure on output (0,3) for 5 cycles.
    fill(1, 1);
    run(0, 0, 3, 5, 1'b0, 1'b0, 0, cyc);
    check("bp_cycles", cyc, 122);
    check("bp_y03", y_got[0][3], 4);
    check("bp_y10", y_got[1][0], 2);

    // Protocol: start/write while busy ignored; write alongside start is used.
    fill_random();
    run(0, 0, 0, 0, 1'b1, 1'b0, 0, cyc);
    run(0, 0, 0, 0, 1'b0, 1'b1, x_m[1][1] ^ 5, cyc);

    for (int it = 0; it < 3; it++) begin
      fill_random();
      run(1, 0, 0, 0, 1'b0, 1'b0, 0, cyc);
    end

    // Reset at cycle 40 of a run.
    fill(1, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 1;
    while (cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("pre_rst_busy", int'(busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_y_valid", int'(y_valid), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_ld_ready", int'(ld_ready), 1);
    check("mid_rst_y_data", int'(y_data), 0);
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done || y_valid || busy) cnt++;
    end
    check("mid_rst_quiet", cnt, 0);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        x_m[r][c] = 0;
        h_m[r][c] = 0;
      end
    run(0, 0, 0, 0, 1'b0, 1'b0, 0, cyc);
    check("cleared_y33", y_got[3][3], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
